// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the forwarding logic.
//   fwd_sel_t   : EX operand bypass select encoding
//   stage_tag_t : destination tag carried by an in-flight pipeline stage
//   ZERO_REG    : index of XZR, which is never a forwarding source
package pipe_pkg;

    localparam int PIPE_REG_W = 5;
    localparam int PIPE_CNT_W = 16;
    localparam logic [PIPE_REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational bypass select for one EX source operand.
// Compares the source index against the EX/MEM and MEM/WB destination tags;
// the younger EX/MEM producer wins when both match. XZR never matches.
// Ports:
//   src          : source register index of the instruction in EX
//   ex_valid/ex_rd/ex_reg_write : EX/MEM producer tag
//   wb_valid/wb_rd/wb_reg_write : MEM/WB producer tag
//   sel          : 00 regfile, 10 EX/MEM, 01 MEM/WB
module fwd_match #(
    parameter int REG_W    = 5,
    parameter int ZERO_IDX = 31
) (
    input  logic [REG_W-1:0] src,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       sel
);
    import pipe_pkg::*;

    localparam logic [REG_W-1:0] ZERO_RD = REG_W'(ZERO_IDX);

    logic     ex_hit_s;
    logic     wb_hit_s;
    fwd_sel_t sel_s;

    // Producer hit detection per stage
    always_comb begin
        ex_hit_s = ex_valid & ex_reg_write & (ex_rd == src) & (ex_rd != ZERO_RD);
        wb_hit_s = wb_valid & wb_reg_write & (wb_rd == src) & (wb_rd != ZERO_RD);
    end

    // Priority select: youngest producer first
    always_comb begin
        sel_s = FWD_RF;
        case ({ex_hit_s, wb_hit_s})
            2'b10, 2'b11: sel_s = FWD_EXMEM;
            2'b01:        sel_s = FWD_MEMWB;
            2'b00:        sel_s = FWD_RF;
            default:      sel_s = FWD_RF;
        endcase
    end

    assign sel = sel_s;

endmodule

// File: rtl/forward_unit.sv
// EX-stage operand forwarding unit.
// Keeps a shadow ID/EX -> EX/MEM -> MEM/WB copy of in-flight destination
// tags and drives the operand bypass selects for the instruction in EX.
// Stall and flush decisions come from the load-use hazard detector.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   stall_in, flush_in    : bubble into EX / squash younger instructions
//   id_valid, id_Rn, id_Rm, id_Rd, id_regWrite, id_memRead : ID-stage instruction
//   fwdA, fwdB            : EX operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   exmem_load            : EX/MEM holds a valid load
//   fwd_count             : saturating count of cycles with any forward active
//   bubble_count          : saturating count of bubble-inserting cycles
module forward_unit #(
    parameter int REG_W    = pipe_pkg::PIPE_REG_W,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = pipe_pkg::PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_Rn,
    input  logic [REG_W-1:0] id_Rm,
    input  logic [REG_W-1:0] id_Rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             exmem_load,
    output logic [CNT_W-1:0] fwd_count,
    output logic [CNT_W-1:0] bubble_count
);
    import pipe_pkg::*;

    localparam stage_tag_t BUBBLE_TAG = '{valid: 1'b0, rd: '0, reg_write: 1'b0, mem_read: 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_tag_t       idex_tag_r;
    logic [REG_W-1:0] idex_rn_r;
    logic [REG_W-1:0] idex_rm_r;
    stage_tag_t       exmem_tag_r;
    logic             memwb_valid_r;
    logic [REG_W-1:0] memwb_rd_r;
    logic             memwb_reg_write_r;
    logic [CNT_W-1:0] fwd_count_r;
    logic [CNT_W-1:0] bubble_count_r;
    logic [1:0]       sel_a_s;
    logic [1:0]       sel_b_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    // Shadow pipeline advance; flush squashes both younger stages, MEM/WB always advances
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_tag_r        <= BUBBLE_TAG;
            idex_rn_r         <= '0;
            idex_rm_r         <= '0;
            exmem_tag_r       <= BUBBLE_TAG;
            memwb_valid_r     <= 1'b0;
            memwb_rd_r        <= '0;
            memwb_reg_write_r <= 1'b0;
        end else begin
            memwb_valid_r     <= exmem_tag_r.valid;
            memwb_rd_r        <= exmem_tag_r.rd;
            memwb_reg_write_r <= exmem_tag_r.reg_write;
            if (flush_in) begin
                idex_tag_r  <= BUBBLE_TAG;
                idex_rn_r   <= '0;
                idex_rm_r   <= '0;
                exmem_tag_r <= BUBBLE_TAG;
            end else if (stall_in) begin
                idex_tag_r  <= BUBBLE_TAG;
                idex_rn_r   <= '0;
                idex_rm_r   <= '0;
                exmem_tag_r <= idex_tag_r;
            end else begin
                idex_tag_r  <= '{valid: id_valid, rd: id_Rd, reg_write: id_regWrite,
                                 mem_read: id_memRead};
                idex_rn_r   <= id_Rn;
                idex_rm_r   <= id_Rm;
                exmem_tag_r <= idex_tag_r;
            end
        end
    end

    fwd_match #(.REG_W(REG_W), .ZERO_IDX(ZERO_REG)) u_match_a (
        .src          (idex_rn_r),
        .ex_valid     (exmem_tag_r.valid),
        .ex_rd        (exmem_tag_r.rd),
        .ex_reg_write (exmem_tag_r.reg_write),
        .wb_valid     (memwb_valid_r),
        .wb_rd        (memwb_rd_r),
        .wb_reg_write (memwb_reg_write_r),
        .sel          (sel_a_s)
    );

    fwd_match #(.REG_W(REG_W), .ZERO_IDX(ZERO_REG)) u_match_b (
        .src          (idex_rm_r),
        .ex_valid     (exmem_tag_r.valid),
        .ex_rd        (exmem_tag_r.rd),
        .ex_reg_write (exmem_tag_r.reg_write),
        .wb_valid     (memwb_valid_r),
        .wb_rd        (memwb_rd_r),
        .wb_reg_write (memwb_reg_write_r),
        .sel          (sel_b_s)
    );

    // A bubble in EX has no operands to bypass
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (idex_tag_r.valid) begin
            fwd_a_s = sel_a_s;
            fwd_b_s = sel_b_s;
        end else begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
        end
    end

    // Saturating count of cycles with an active forward
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_count_r <= '0;
        end else if (((fwd_a_s != 2'b00) || (fwd_b_s != 2'b00)) && (fwd_count_r != CNT_MAX)) begin
            fwd_count_r <= fwd_count_r + CNT_ONE;
        end else begin
            fwd_count_r <= fwd_count_r;
        end
    end

    // Saturating count of cycles that inserted a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_r <= '0;
        end else if ((stall_in || flush_in) && (bubble_count_r != CNT_MAX)) begin
            bubble_count_r <= bubble_count_r + CNT_ONE;
        end else begin
            bubble_count_r <= bubble_count_r;
        end
    end

    assign fwdA         = fwd_a_s;
    assign fwdB         = fwd_b_s;
    assign exmem_load   = exmem_tag_r.valid & exmem_tag_r.mem_read;
    assign fwd_count    = fwd_count_r;
    assign bubble_count = bubble_count_r;

endmodule

// File: tb/tb_forward_unit.sv
module tb_forward_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall_in = 1'b0;
    logic       flush_in = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_Rn = 5'd0;
    logic [4:0] id_Rm = 5'd0;
    logic [4:0] id_Rd = 5'd0;
    logic       id_regWrite = 1'b0;
    logic       id_memRead = 1'b0;

    logic [1:0]  fwdA, fwdB, fwdA4, fwdB4;
    logic        exmem_load, exmem_load4;
    logic [15:0] fwd_count, bubble_count;
    logic [3:0]  fwd_count4, bubble_count4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    forward_unit dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .fwdA(fwdA), .fwdB(fwdB), .exmem_load(exmem_load),
        .fwd_count(fwd_count), .bubble_count(bubble_count)
    );

    forward_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .fwdA(fwdA4), .fwdB(fwdB4), .exmem_load(exmem_load4),
        .fwd_count(fwd_count4), .bubble_count(bubble_count4)
    );

    // Reference model: the instruction occupying each stage, oldest last
    typedef struct {
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } minst_t;

    localparam minst_t NOP = '{v: 1'b0, rn: 5'd0, rm: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0};

    minst_t m_id = NOP;
    minst_t m_exm = NOP;
    minst_t m_mwb = NOP;
    int     m_fwd = 0;
    int     m_bub = 0;

    // Youngest in-flight writer of src supplies the operand; XZR is never bypassed
    function automatic logic [1:0] exp_sel(input logic [4:0] src);
        minst_t prod [2];
        prod[0] = m_exm;
        prod[1] = m_mwb;
        if (!m_id.v) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (prod[k].v && prod[k].rw && prod[k].rd == src && src != 5'd31)
                return (k == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("fwdA",       32'(fwdA),          32'(exp_sel(m_id.rn)));
        check("fwdB",       32'(fwdB),          32'(exp_sel(m_id.rm)));
        check("fwdA_c4",    32'(fwdA4),         32'(exp_sel(m_id.rn)));
        check("fwdB_c4",    32'(fwdB4),         32'(exp_sel(m_id.rm)));
        check("exmem_load", 32'(exmem_load),    32'(m_exm.v && m_exm.mr));
        check("fwd_cnt",    32'(fwd_count),     32'(sat(m_fwd, 65535)));
        check("bub_cnt",    32'(bubble_count),  32'(sat(m_bub, 65535)));
        check("fwd_cnt4",   32'(fwd_count4),    32'(sat(m_fwd, 15)));
        check("bub_cnt4",   32'(bubble_count4), 32'(sat(m_bub, 15)));
    endtask

    // One clock: drive ID inputs, advance the model, then compare
    task automatic step(input logic rst, input logic st, input logic fl, input logic v,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic rw, input logic mr);
        logic   nz;
        minst_t inst;
        reset = rst; stall_in = st; flush_in = fl; id_valid = v;
        id_Rn = rn; id_Rm = rm; id_Rd = rd; id_regWrite = rw; id_memRead = mr;
        nz = (exp_sel(m_id.rn) != 2'b00) || (exp_sel(m_id.rm) != 2'b00);
        inst = '{v: v, rn: rn, rm: rm, rd: rd, rw: rw, mr: mr};
        @(posedge clk);
        if (rst) begin
            m_id = NOP; m_exm = NOP; m_mwb = NOP; m_fwd = 0; m_bub = 0;
        end else begin
            if (nz) m_fwd++;
            if (st || fl) m_bub++;
            m_mwb = m_exm;
            if (fl) begin
                m_exm = NOP;
                m_id  = NOP;
            end else begin
                m_exm = m_id;
                m_id  = st ? NOP : inst;
            end
        end
        #1;
        check_all();
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        rst_cycle();
        check("rst_fwdA", 32'(fwdA), 32'd0);
        check("rst_cnt",  32'(fwd_count), 32'd0);

        // ADD X1 then SUB ..,X1,X2
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        check("t1_fwdA", 32'(fwdA), 32'd2);
        check("t1_fwdB", 32'(fwdB), 32'd0);
        nop();
        check("t1_cnt", 32'(fwd_count), 32'd1);

        // ADD X3; NOP; ORR ..,X2,X3 -> MEM/WB forward on B
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd3, 1'b1, 1'b0);
        nop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b0);
        check("t2_wb", 32'(fwdB), 32'd1);
        // ADD X3; ADD X3; use X3 -> EX/MEM wins
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd6, 5'd3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b0);
        check("t2_ex", 32'(fwdB), 32'd2);

        // XZR producer never forwards
        rst_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 5'd31, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd2, 5'd4, 1'b1, 1'b0);
        check("t3_ex", 32'(fwdA), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd2, 5'd4, 1'b1, 1'b0);
        check("t3_wb", 32'(fwdA), 32'd0);

        // LDUR X5; ADD ..,X5 with one stall cycle
        rst_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
        check("t4_bub_fwd", 32'(fwdA), 32'd0);
        check("t4_bub_cnt", 32'(bubble_count), 32'd1);
        check("t4_load", 32'(exmem_load), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
        check("t4_wb", 32'(fwdA), 32'd1);

        // Flush with a matching producer in ID/EX
        rst_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 1'b0);
        check("t5_exmem", 32'(exmem_load), 32'd0);
        check("t5_fwdA", 32'(fwdA), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 1'b0);
        check("t5_sq", 32'(fwdA), 32'd0);

        // 20 forwarding cycles saturate the 4-bit counter
        rst_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd1, 1'b1, 1'b0);
        for (int i = 0; i < 21; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0);
        check("t6_sat4", 32'(fwd_count4), 32'd15);
        check("t6_cnt16", 32'(fwd_count), 32'd20);

        // Mid-stream reset
        rst_cycle();
        check("t6_rst_fwdA", 32'(fwdA), 32'd0);
        check("t6_rst_cnt", 32'(fwd_count4), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [4:0] rn, rm, rd;
            rn = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(7));
            rm = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(7));
            rd = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(7));
            step(1'($urandom_range(149) == 0), 1'($urandom_range(7) == 0),
                 1'($urandom_range(15) == 0), 1'($urandom_range(5) != 0),
                 rn, rm, rd, 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
